// File: rtl/mem_access_pkg.sv
//==============================================================================
// Module   : mem_access_pkg
// Brief    : Shared mem_op encodings, FSM state codes, default bus timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int c_default_timeout = 16;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Address bits that must be zero for the access size of op.
    function automatic logic [1:0] align_mask(input mem_op_e op);
        logic [1:0] m;
        m = 2'b00;
        case (op)
            OP_LW, OP_SW:         m = 2'b11;
            OP_LH, OP_LHU, OP_SH: m = 2'b01;
            default:              m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane.sv
//==============================================================================
// Module   : mem_lane
// Brief    : Byte-enable generation, store data replication, load extraction.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_lane
    import mem_access_pkg::*;
(
    input  mem_op_e     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'(i_rdata >> {i_addr_lo, 3'b000});
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_load  = i_rdata;
        case (i_op)
            OP_SH: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            OP_SB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'h0000, w_half};
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'h000000, w_byte};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
//==============================================================================
// Module   : mem_access
// Brief    : MEM-stage load/store unit bridging the pipeline to a word bus.
//            Define MEM_ALIGN_CHECK_EN to trap misaligned word/half accesses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_default_timeout
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    state_e               r_state;
    state_e               w_next;
    mem_op_e              r_op;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_rdata;
    logic                 r_bus_err;
    mem_op_e              w_op;
    logic                 w_accept;
    logic                 w_misaligned;
    logic                 w_timeout;
    logic [31:0]          w_addr_fixed;
    logic [3:0]           w_be;
    logic [31:0]          w_wrep;
    logic [31:0]          w_load;

    assign w_op         = mem_op_e'(mem_op);
    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_timeout    = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
    // Without the trap, misaligned low bits are simply dropped.
    assign w_addr_fixed = {addr[31:2], addr[1:0] & ~align_mask(w_op)};

`ifdef MEM_ALIGN_CHECK_EN
    logic r_exc_adel;
    logic r_exc_ades;

    assign w_misaligned = |(addr[1:0] & align_mask(w_op));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc_adel <= 1'b0;
            r_exc_ades <= 1'b0;
        end else if (w_accept) begin
            r_exc_adel <= w_misaligned && !is_store(w_op);
            r_exc_ades <= w_misaligned && is_store(w_op);
        end
    end

    assign exc_adel = r_exc_adel;
    assign exc_ades = r_exc_ades;
`else
    assign w_misaligned = 1'b0;
    assign exc_adel     = 1'b0;
    assign exc_ades     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        stall     = 1'b1;
        rsp_valid = 1'b0;
        bus_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid) w_next = w_misaligned ? ST_RESP : ST_BUS;
            end
            ST_BUS: begin
                bus_req = 1'b1;
                if (bus_ack || w_timeout) w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= OP_LW;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_cnt     <= '0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
        end else if (w_accept) begin
            r_op      <= w_op;
            r_addr    <= w_addr_fixed;
            r_wdata   <= wdata;
            r_cnt     <= '0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
        end else if (r_state == ST_BUS) begin
            if (bus_ack) begin
                r_rdata <= is_store(r_op) ? 32'h0 : w_load;
            end else if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    mem_lane u_lane (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (bus_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wrep),
        .o_load    (w_load)
    );

    // Bus outputs are gated so they read zero whenever no transfer is open.
    assign bus_we    = bus_req && is_store(r_op);
    assign bus_addr  = bus_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus_be    = bus_req ? w_be : 4'b0000;
    assign bus_wdata = bus_req ? w_wrep : 32'h0;
    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
//==============================================================================
// Module   : tb_mem_access
// Brief    : Directed scoreboard bench for mem_access.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  mem_op = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        req_ready, rsp_valid, exc_adel, exc_ades, bus_err, stall;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h5A5A5A5A;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mem_access dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .bus_err   (bus_err),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("exc_adel", {31'd0, exc_adel}, {31'd0, e.adel});
            chk("exc_ades", {31'd0, exc_ades}, {31'd0, e.ades});
            chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        end
    endtask

    // ack_wait < 0 means the bus never acknowledges.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_wait,
                       input logic [31:0] x_addr, input logic [3:0] x_be, input logic x_we,
                       input logic [31:0] x_wd, input int x_lat,
                       input logic [31:0] x_rdata, input logic x_adel, input logic x_ades,
                       input logic x_err);
        int n;
        int cyc;
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        mem_op    = op;
        addr      = a;
        wdata     = wd;
        e.rdata = x_rdata; e.adel = x_adel; e.ades = x_ades; e.err = x_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n   = 1;
        cyc = 0;
        while (bus_req === 1'b1 && n < 40) begin
            chk("bus_addr", bus_addr, x_addr);
            chk("bus_be", {28'd0, bus_be}, {28'd0, x_be});
            chk("bus_we", {31'd0, bus_we}, {31'd0, x_we});
            if (x_we) chk("bus_wdata", bus_wdata, x_wd);
            if (cyc == ack_wait) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 32'h5A5A5A5A;
            n++;
            cyc++;
        end
        if (ack_wait < 0) chk("timeout_bus_cycles", cyc, 32'd16);
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("latency", n, x_lat);
        pop_and_check();
        @(negedge clk);
        chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        // Reset values while reset is held low
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_flags", {29'd0, exc_adel, exc_ades, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 1'b0, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        run(OP_LB,  32'h103, 32'h0, 32'h80123456, 0, 32'h100, 4'b1111, 1'b0, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0);
        run(OP_LBU, 32'h103, 32'h0, 32'h80123456, 0, 32'h100, 4'b1111, 1'b0, 32'h0, 2, 32'h00000080, 1'b0, 1'b0, 1'b0);
        run(OP_LH,  32'h102, 32'h0, 32'h80123456, 0, 32'h100, 4'b1111, 1'b0, 32'h0, 2, 32'hFFFF8012, 1'b0, 1'b0, 1'b0);
        run(OP_LHU, 32'h100, 32'h0, 32'h8012F456, 3, 32'h100, 4'b1111, 1'b0, 32'h0, 5, 32'h0000F456, 1'b0, 1'b0, 1'b0);
        run(OP_LB,  32'h101, 32'h0, 32'h00007F00, 0, 32'h100, 4'b1111, 1'b0, 32'h0, 2, 32'h0000007F, 1'b0, 1'b0, 1'b0);
        run(OP_SB,  32'h201, 32'h000000AB, 32'hFFFFFFFF, 0, 32'h200, 4'b0010, 1'b1, 32'hABABABAB, 2, 32'h0, 1'b0, 1'b0, 1'b0);
        run(OP_SH,  32'h202, 32'h1234CAFE, 32'hFFFFFFFF, 2, 32'h200, 4'b1100, 1'b1, 32'hCAFECAFE, 4, 32'h0, 1'b0, 1'b0, 1'b0);
        run(OP_SW,  32'h204, 32'h12345678, 32'hFFFFFFFF, 1, 32'h204, 4'b1111, 1'b1, 32'h12345678, 3, 32'h0, 1'b0, 1'b0, 1'b0);
        // Timeout: 16 BUS cycles, then RESP with bus_err
        run(OP_LW,  32'h400, 32'h0, 32'h0, -1, 32'h400, 4'b1111, 1'b0, 32'h0, 17, 32'h0, 1'b0, 1'b0, 1'b1);
        run(OP_LW,  32'h404, 32'h0, 32'h01020304, 0, 32'h404, 4'b1111, 1'b0, 32'h0, 2, 32'h01020304, 1'b0, 1'b0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        run(OP_LW,  32'h102, 32'h0, 32'h11111111, 0, 32'h0, 4'b0000, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1'b0);
        run(OP_SH,  32'h203, 32'h0000BEEF, 32'h0, 0, 32'h0, 4'b0000, 1'b0, 32'h0, 1, 32'h0, 1'b0, 1'b1, 1'b0);
`else
        run(OP_LW,  32'h102, 32'h0, 32'h11111111, 0, 32'h100, 4'b1111, 1'b0, 32'h0, 2, 32'h11111111, 1'b0, 1'b0, 1'b0);
        run(OP_SH,  32'h203, 32'h0000BEEF, 32'h0, 0, 32'h200, 4'b1100, 1'b1, 32'hBEEFBEEF, 2, 32'h0, 1'b0, 1'b0, 1'b0);
`endif

        // bus_ack while IDLE has no effect
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_ack_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);

        // req_valid held through RESP: second request only after IDLE returns
        req_valid = 1'b1; mem_op = OP_LW; addr = 32'h300; wdata = 32'h0;
        sb.push_back('{32'hAAAA0001, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        chk("held_bus1", {31'd0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hAAAA0001;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("held_rsp1", {31'd0, rsp_valid}, 32'd1);
        chk("held_ready_resp", {31'd0, req_ready}, 32'd0);
        pop_and_check();
        @(negedge clk);
        chk("held_idle_stall", {31'd0, stall}, 32'd0);
        chk("held_idle_ready", {31'd0, req_ready}, 32'd1);
        addr = 32'h304;
        sb.push_back('{32'hAAAA0002, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        chk("held_bus2", {31'd0, bus_req}, 32'd1);
        chk("held_bus2_addr", bus_addr, 32'h304);
        bus_ack = 1'b1; bus_rdata = 32'hAAAA0002;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("held_rsp2", {31'd0, rsp_valid}, 32'd1);
        pop_and_check();

        // Asynchronous reset mid-BUS
        @(negedge clk);
        req_valid = 1'b1; mem_op = OP_SW; addr = 32'h500; wdata = 32'h1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("async_rst_bus_we", {31'd0, bus_we}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run(OP_LBU, 32'h602, 32'h0, 32'h00C30000, 0, 32'h600, 4'b1111, 1'b0, 32'h0, 2, 32'h000000C3, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning cycles to wait for bus_ack before aborting.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  EX stage presents a memory access.
REQ-005 SHALL have port mem_op  input  3  access type: LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-006 SHALL have port addr  input  32  byte address, the ALU result.
REQ-007 SHALL have port wdata  input  32  store data (rt value).
REQ-008 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle pulse: access complete.
REQ-010 SHALL have port rdata  output  32  extended load result, valid with rsp_valid.
REQ-011 SHALL have port exc_adel / exc_ades  output  1 each  load / store address-error flags, valid with rsp_valid.
REQ-012 SHALL have port bus_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 SHALL have port stall  output  1  high whenever state is not IDLE.
REQ-014 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_be out 4, bus_wdata out 32, bus_ack in 1, bus_rdata in 32 (word-wide memory bus).

Function
REQ-015 SHALL implement FSM states IDLE, BUS, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready, latching mem_op, addr and wdata.
REQ-017 On acceptance of an aligned request SHALL enter BUS next cycle, with bus_req=1, bus_addr={addr[31:2],2'b00} and bus_we=1 for stores.
REQ-018 SHALL hold bus_req and all bus_* outputs stable in BUS until the cycle bus_ack=1, then enter RESP.
REQ-019 bus_be: SW 4'b1111; SH addr[1]?4'b1100:4'b0011; SB 4'b0001<<addr[1:0]; loads 4'b1111.
REQ-020 bus_wdata: SW wdata; SH {2{wdata[15:0]}}; SB {4{wdata[7:0]}}.
REQ-021 Load extraction on bus_ack: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; the result is registered into rdata.
REQ-022 In RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; stores SHALL give rdata=0.
REQ-023 Request-to-rsp_valid latency SHALL be 2 cycles + bus wait (bus_ack in the first BUS cycle gives rsp_valid 2 cycles after acceptance).
REQ-024 A cycle counter SHALL reset on entering BUS; if TIMEOUT_CYCLES BUS cycles pass without bus_ack, SHALL drop bus_req, go to RESP and flag bus_err=1.
REQ-025 bus_ack outside BUS SHALL be ignored.
REQ-026 A req_valid held across RESP SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-027 While reset is low SHALL force IDLE immediately (asynchronously), even mid-transfer.
REQ-028 Reset values: bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rsp_valid=0, rdata=0, exc_adel=0, exc_ades=0, bus_err=0, counter=0, req_ready=1, stall=0.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0, SHALL skip BUS, enter RESP next cycle with exc_adel (loads) or exc_ades (stores) set, and SHALL NOT assert bus_req.
REQ-030 MEM_ALIGN_CHECK_EN undefined: SHALL force the offending low address bits to zero, perform the access, and hold exc_adel/exc_ades constant 0.

Structure
REQ-031 mem_op encodings, FSM state codes and the default timeout SHALL live in the shared global defines header.
REQ-032 Byte-enable generation, store replication and load extraction SHALL be a combinational sub-module mem_lane; mem_access holds the FSM, counter and registers.

Verification
REQ-033 LW addr=0x100, bus_ack in first BUS cycle, bus_rdata=0xDEADBEEF -> rsp_valid 2 cycles after acceptance, rdata=0xDEADBEEF.
REQ-034 LB addr=0x103, bus_rdata=0x80123456 -> rdata=0xFFFFFF80; LBU -> 0x00000080; LH addr=0x102 -> 0xFFFF8012.
REQ-035 SB addr=0x201, wdata=0x000000AB -> bus_be=4'b0010, bus_wdata=0xABABABAB, bus_we=1, bus_addr=0x200.
REQ-036 bus_ack never asserted -> bus_req drops after 16 BUS cycles, rsp_valid with bus_err=1.
REQ-037 With MEM_ALIGN_CHECK_EN, LW addr=0x102 -> no bus_req, rsp_valid next cycle with exc_adel=1; without the macro, bus_addr=0x100 and exc_adel=0.
REQ-038 reset driven low mid-BUS -> bus_req=0 and stall=0 immediately, req_ready=1.
